// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline registers: per-stage control
// structs, their widths and their all-zero bubble values.
package pipe_pkg;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
  } mem_wb_ctrl_t;

  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

  // A bubble carries no RegWrite/MemWrite, so an invalid slot is harmless.
  localparam ex_mem_ctrl_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_ctrl_t MEM_WB_BUBBLE = '0;

  // Number of valid entries from the two entry valid bits.
  function automatic logic [1:0] occCount(input logic mainV, input logic skidV);
    return {1'b0, mainV} + {1'b0, skidV};
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+payload entry. clear has priority over load; a cleared entry
// holds BUBBLE so its payload is inert whenever it is invalid.
module pipe_skid_slot #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] loadData,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Entry register: reset/clear to bubble, load marks the entry valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      data  <= loadData;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready back-pressure and
// hazard flush. Optional feature macro: PIPE_STAGE_SKID_EN adds a skid entry
// and makes up_ready a register.
//
// Handshake: a beat moves on an edge where valid && ready are both high on
// that side (up_valid && up_ready in, dn_valid && dn_ready out); a producer
// holds valid and data stable until the beat moves; ready may change freely.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = EX_MEM_CTRL_W,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready,
  output logic [1:0]       occupancy
);

  logic             xferIn;
  logic             xferOut;
  logic             mainValid;
  logic [WIDTH-1:0] mainData;
  logic             mainLoad;
  logic             mainClear;
  logic [WIDTH-1:0] mainLoadData;

  assign xferIn    = up_valid && up_ready;
  assign xferOut   = mainValid && dn_ready;
  assign dn_valid  = mainValid;
  assign dn_data   = mainData;

  pipe_skid_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) uMain (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (mainClear),
    .load     (mainLoad),
    .loadData (mainLoadData),
    .valid    (mainValid),
    .data     (mainData)
  );

`ifdef PIPE_STAGE_SKID_EN

  logic             skidValid;
  logic [WIDTH-1:0] skidData;
  logic             skidLoad;
  logic             skidClear;
  logic             skidNextValid;
  logic             upReadyReg;

  pipe_skid_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) uSkid (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (skidClear),
    .load     (skidLoad),
    .loadData (up_data),
    .valid    (skidValid),
    .data     (skidData)
  );

  // Priority flush > transfer; main refills from skid so beat order holds.
  always_comb begin
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    mainLoadData = up_data;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    if (flush) begin
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else if (xferOut) begin
      if (skidValid) begin
        mainLoad     = 1'b1;
        mainLoadData = skidData;
        skidClear    = 1'b1;
      end else if (xferIn) begin
        mainLoad = 1'b1;
      end else begin
        mainClear = 1'b1;
      end
    end else if (xferIn) begin
      if (mainValid) skidLoad = 1'b1;
      else           mainLoad = 1'b1;
    end
  end

  // Next skid valid, so up_ready can be registered without a dn_ready path.
  always_comb begin
    skidNextValid = 1'b0;
    if (!flush) begin
      if (skidValid) skidNextValid = !xferOut;
      else           skidNextValid = xferIn && mainValid && !xferOut;
    end
  end

  // Registered ready mirrors "skid entry empty" after each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upReadyReg <= 1'b1;
    else        upReadyReg <= !skidNextValid;
  end

  assign up_ready  = upReadyReg;
  assign occupancy = occCount(mainValid, skidValid);

`else

  // Single entry: flush > load on transfer in > bubble on drain > hold.
  always_comb begin
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    mainLoadData = up_data;
    if (flush)        mainClear = 1'b1;
    else if (xferIn)  mainLoad  = 1'b1;
    else if (xferOut) mainClear = 1'b1;
  end

  // Flush always consumes the incoming beat so upstream never stalls on it.
  assign up_ready  = flush || !mainValid || dn_ready;
  assign occupancy = occCount(mainValid, 1'b0);

`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the pipelined RISC-V core with hazard handling. It replaces the fixed per-stage control registers (E→M, M→W) with one generic stage carrying a WIDTH-bit packed payload (control and/or datapath fields), a valid bit, valid/ready back-pressure and a hazard-unit flush. A bubble value is loaded on reset, flush and drain, so invalid slots can never carry a live RegWrite or MemWrite. One instance sits between each pair of adjacent pipeline stages.

## Interface
- WIDTH, 4: payload width in bits (4 = {RegWrite, ResultSrc[1:0], MemWrite}).
- BUBBLE, '0: payload value held whenever the output slot is invalid.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  hazard-unit squash of the stage contents and the incoming beat.
- up_valid  input  1  upstream beat valid.
- up_data  input  WIDTH  upstream payload.
- up_ready  output  1  stage accepts a beat this cycle.
- dn_valid  output  1  downstream beat valid (registered).
- dn_data  output  WIDTH  downstream payload (registered).
- dn_ready  input  1  downstream accepts a beat (low = stall).
- occupancy  output  2  number of beats held: 0..1 without skid, 0..2 with skid.

## Operation
- Transfer in: up_valid && up_ready. Transfer out: dn_valid && dn_ready.
- Priority per edge: reset > flush > transfer in/out > hold.
- flush: all held entries become invalid and their payloads become BUBBLE. Any beat presented the same cycle is dropped. up_ready is 1 during flush, so upstream treats the beat as consumed.
- Base mode (one entry):
  - up_ready = !dn_valid || dn_ready (combinational).
  - Transfer in: the entry takes up_data and valid = 1.
  - Transfer out without transfer in: valid = 0 and payload = BUBBLE.
  - Neither: hold.
- dn_data equals BUBBLE whenever dn_valid = 0. This comes from the registered value, not from output masking.
- occupancy equals the count of valid entries, updated at the same edge as those entries.

## Timing
- Reset values: dn_valid = 0, dn_data = BUBBLE, occupancy = 0. up_ready = 1 while rst_n is low and on the first cycle after release.
- Latency: 1 cycle from transfer in to dn_valid.
- Throughput: 1 beat per cycle with dn_ready held high.
- Stall (dn_ready = 0, entry full): dn_data and dn_valid hold stable and up_ready = 0.
- Simultaneous transfer in and transfer out: the entry is replaced with the new payload; valid stays 1 and there is no bubble.
- rst_n asserting mid-stream clears all entries immediately, independent of clk. No beat survives reset.
- Flush in the same cycle as dn_ready = 1: the downstream transfer of the current beat still completes on that edge (the consumer samples it). The stage is empty afterwards.

## Configuration
- PIPE_STAGE_SKID_EN defined: adds a second (skid) entry.
  - up_ready becomes a register equal to !skid_valid, with no combinational path from dn_ready.
  - A transfer in while main is full and dn_ready = 0 fills the skid entry.
  - On transfer out, main takes the skid entry and the skid entry resets to BUBBLE/invalid.
  - Beat order is preserved. Flush clears both entries.
- PIPE_STAGE_SKID_EN undefined: single entry as described under Operation. up_ready is combinational.

## Structure
- Package pipe_pkg holds:
  - the stage control structs: ex_mem_ctrl_t {RegWrite, ResultSrc[1:0], MemWrite} and mem_wb_ctrl_t {RegWrite, ResultSrc[1:0]};
  - their widths, as localparams derived from $bits;
  - the matching BUBBLE constants, all-zero control.
- One sub-module: pipe_skid_slot (a single valid+payload entry with load/clear), instantiated once or twice. The top holds only handshake and priority logic.

## Test plan
- Reset: hold rst_n low for 3 cycles with up_valid = 1 and up_data = 4'hF → dn_valid = 0, dn_data = 4'h0, occupancy = 0. Release rst_n, present the beat → dn_data = 4'hF one cycle later.
- Streaming: send 4'h1..4'h8 back-to-back with dn_ready = 1 → the same sequence appears on dn_data, delayed 1 cycle, with no gaps and occupancy = 1.
- Stall: hold 4'h9 with dn_ready = 0 for 4 cycles.
  - Base: up_ready = 0 and dn_data stays 4'h9.
  - Skid: 4'hA is accepted into the skid entry, then up_ready = 0 and occupancy = 2. On release, 4'h9 then 4'hA are delivered.
- Flush: stage full with 4'hB, flush = 1 while up_valid = 1 and up_data = 4'hC → next cycle dn_valid = 0, dn_data = 4'h0, and 4'hC never appears.
- Flush with skid full → both entries are cleared, occupancy = 0, and up_ready = 1 on the following cycle.
- Async reset mid-stall: pulse rst_n low between clock edges → dn_valid falls before the next edge and occupancy = 0.
